contador_minas: RTL and testbench

Neighbour-count stage for the Buscaminas board. On a start pulse it latches a flattened 8×8 mine map and walks every cell once, one cell per clock. For each cell it emits a write beat (address plus the number of mined neighbours) that the board matrix stores as the value revealed to the player. It sits between mine placement and the `matriz` storage, driven by the game controller.

---
 rtl/contador_minas.sv | 73 +++++++
 tb/tb_contador_minas.sv | 116 +++++++++++
 2 files changed

// File: rtl/contador_minas.sv
// contador_minas: scans a latched 8x8 mine map and emits one neighbour-count write beat per cell (optional CONTADOR_MARCA_MINA_EN marks mined cells with 9)
module contador_minas #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int AW   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] mine_map,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [3:0]           wr_count
);
  localparam int N = ROWS * COLS;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t         r_state, w_next;
  logic [N-1:0]   r_map;
  logic [AW-1:0]  r_idx;
  logic [3:0]     w_cnt;
`ifdef CONTADOR_MARCA_MINA_EN
  logic [N-1:0]   w_sh;
`endif
  function automatic logic [3:0] count_at(input logic [N-1:0] m, input int i);
    int r, c;
    logic [N-1:0] s;
    logic [3:0] n;
    r = i / COLS;
    c = i % COLS;
    n = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS && c + dc >= 0 && c + dc < COLS) begin
          s = m >> ((r + dr) * COLS + c + dc);
          n = n + {3'b000, s[0]};
        end
    return n;
  endfunction
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  // next state: accept start in IDLE, leave SCAN after the last cell, DONE lasts one cycle
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? SCAN : IDLE) :
             (r_state == SCAN) ? ((r_idx == AW'(N - 1)) ? DONE : SCAN) : IDLE;
  end
  // latch the map on acceptance and step the cell index through the scan
  always_ff @(posedge clk)
    if (reset) begin
      r_map <= '0;
      r_idx <= '0;
    end else if (r_state == IDLE && start) begin
      r_map <= mine_map;
      r_idx <= '0;
    end else if (r_state == SCAN)
      r_idx <= r_idx + 1'b1;
  // outputs decoded from registered state only
  always_comb begin
    w_cnt   = count_at(r_map, int'(r_idx));
    busy    = r_state != IDLE;
    done    = r_state == DONE;
    wr_en   = r_state == SCAN;
    wr_addr = r_idx;
`ifdef CONTADOR_MARCA_MINA_EN
    w_sh     = r_map >> r_idx;
    wr_count = wr_en ? (w_sh[0] ? 4'd9 : w_cnt) : 4'd0;
`else
    wr_count = wr_en ? w_cnt : 4'd0;
`endif
  end
endmodule

// File: tb/tb_contador_minas.sv
// tb_contador_minas: randomized and directed scans checked against a grid-based neighbour model
module tb_contador_minas;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [63:0] mine_map = '0;
  logic        busy, done, wr_en;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_count;
  int total = 0;
  int bad = 0;

  contador_minas dut (
    .clk(clk), .reset(reset), .start(start), .mine_map(mine_map),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    if (obs != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int is_mine(input logic [63:0] m, input int r, input int c);
    return int'((m >> (r * 8 + c)) & 64'd1);
  endfunction

  function automatic int exp_cnt(input logic [63:0] m, input int a);
    int r, c, n;
    r = a / 8;
    c = a % 8;
    n = 0;
`ifdef CONTADOR_MARCA_MINA_EN
    if (is_mine(m, r, c) == 1) return 9;
`endif
    for (int rr = r - 1; rr <= r + 1; rr++)
      for (int cc = c - 1; cc <= c + 1; cc++)
        if (!(rr == r && cc == c) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
          n += is_mine(m, rr, cc);
    return n;
  endfunction

  task automatic run_scan(input logic [63:0] m, input logic [63:0] m2, input int poke_at, input int abort_at);
    @(negedge clk);
    mine_map = m;
    start = 1;
    @(negedge clk);
    start = 0;
    mine_map = ~m;
    for (int k = 0; k < 64; k++) begin
      chk("busy", busy, 1);
      chk("wr_en", wr_en, 1);
      chk("wr_addr", wr_addr, k);
      chk("wr_count", wr_count, exp_cnt(m, k));
      chk("done_in_scan", done, 0);
      if (k == abort_at) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
          chk("abort_idle", busy, 0);
        end
        return;
      end
      start = (k == poke_at);
      if (k == poke_at) mine_map = m2;
      @(negedge clk);
    end
    start = 0;
    chk("end_wr_en", wr_en, 0);
    chk("end_done", done, 1);
    chk("end_busy", busy, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_wr_en", wr_en, 0);
    @(negedge clk);
    chk("stay_idle", busy, 0);
    chk("stay_done", done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_count", wr_count, 0);
    mine_map = '1;
    start = 1;
    @(negedge clk);
    chk("rst_priority", busy, 0);
    start = 0;
    reset = 0;
    run_scan(64'h0, 64'h0, -1, -1);
    run_scan('1, 64'h0, -1, -1);
    run_scan(64'd1 << 27, 64'h0, -1, -1);
    run_scan((64'd1 << 7) | 64'd1, 64'h0, -1, -1);
    run_scan({$urandom, $urandom}, 64'h0, -1, 20);
    run_scan({$urandom, $urandom}, 64'h0, -1, -1);
    run_scan({$urandom, $urandom}, '1, 40, -1);
    for (int t = 0; t < 6; t++)
      run_scan({$urandom, $urandom} & {$urandom, $urandom} | ($urandom_range(0, 1) == 1 ? 64'h8100_0000_0000_0081 : 64'h0), 64'h0, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
